// File: rtl/ibexsis_bus_pkg.sv
// ---------------------------------------------------------------------------
// ibexsis_bus_pkg: default data-bus address map and slave-index types. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ibexsis_bus_pkg;

   localparam int unsigned NSLV_DEF = 4;
   localparam int unsigned AW_DEF   = 32;

   // Index 0 = RAM, 1 = IO module, 2 = UART0, 3 = Timer
   localparam logic [NSLV_DEF-1:0][AW_DEF-1:0] BASE_DEF =
      {32'h0000_2014, 32'h0000_2004, 32'h0000_2000, 32'h0000_1000};
   localparam logic [NSLV_DEF-1:0][AW_DEF-1:0] SIZE_DEF =
      {32'h0000_0020, 32'h0000_0010, 32'h0000_0004, 32'h0000_1000};

   localparam int unsigned IDX_W = $clog2(NSLV_DEF + 1);
   typedef logic [IDX_W-1:0] slv_idx_t;
   localparam slv_idx_t ERR_IDX = slv_idx_t'(NSLV_DEF);

endpackage

`default_nettype wire

// File: rtl/resp_id_fifo.sv
// ---------------------------------------------------------------------------
// resp_id_fifo: synchronous FIFO of outstanding response IDs. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module resp_id_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned W     = 3
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] dout_o,
   output logic         full_o,
   output logic         empty_o,
   output logic [W-1:0] last_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  last_q;
   logic          do_push, do_pop;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign dout_o  = mem_q[rptr_q];
   assign last_o  = last_q;
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (do_push) wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
      if (do_pop)  rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
      if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         last_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
         if (do_push) begin
            mem_q[wptr_q] <= din_i;
            last_q        <= din_i;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/dbus_decoder.sv
// ---------------------------------------------------------------------------
// dbus_decoder: parametrised CPU data-bus router with in-order responses. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dbus_decoder
   import ibexsis_bus_pkg::*;
#(
   parameter int unsigned NSLV  = NSLV_DEF,
   parameter int unsigned DW    = 32,
   parameter int unsigned AW    = AW_DEF,
   parameter int unsigned SW    = 4,
   parameter int unsigned OUTST = 2,
   parameter logic [NSLV-1:0][AW-1:0] BASE = BASE_DEF,
   parameter logic [NSLV-1:0][AW-1:0] SIZE = SIZE_DEF
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               data_req_i,
   output logic               data_gnt_o,
   input  logic               data_we_i,
   input  logic [SW-1:0]      data_be_i,
   input  logic [AW-1:0]      data_addr_i,
   input  logic [DW-1:0]      data_wdata_i,
   output logic               data_rvalid_o,
   output logic [DW-1:0]      data_rdata_o,
   output logic               data_err_o,
   output logic [NSLV-1:0]    s_req_o,
   output logic               s_we_o,
   output logic [SW-1:0]      s_be_o,
   output logic [AW-1:0]      s_addr_o,
   output logic [DW-1:0]      s_wdata_o,
   input  logic [NSLV-1:0]    s_rvalid_i,
   input  logic [NSLV*DW-1:0] s_rdata_i
);

   localparam int unsigned IW  = $clog2(NSLV + 1);
   localparam logic [IW-1:0] ERR = IW'(NSLV);

   logic [IW-1:0] target, head, last;
   logic [AW-1:0] offset;
   logic          full, empty, pop;

   // Descending scan so the lowest matching index wins
   always_comb begin
      target = ERR;
      offset = '0;
      for (int k = NSLV - 1; k >= 0; k--) begin
         if (({1'b0, data_addr_i} >= {1'b0, BASE[k]}) &&
             ({1'b0, data_addr_i} <  ({1'b0, BASE[k]} + {1'b0, SIZE[k]}))) begin
            target = IW'(k);
            offset = data_addr_i - BASE[k];
         end
      end
   end

   // Switching targets only from an empty FIFO keeps responses in order
   assign data_gnt_o = data_req_i && !full && (empty || (target == last));

   always_comb begin
      s_req_o = '0;
      for (int k = 0; k < NSLV; k++) begin
         s_req_o[k] = data_gnt_o && (target == IW'(k));
      end
   end

   assign s_we_o    = data_we_i;
   assign s_be_o    = data_be_i;
   assign s_addr_o  = offset;
   assign s_wdata_o = data_wdata_i;

   always_comb begin
      data_rvalid_o = 1'b0;
      data_err_o    = 1'b0;
      data_rdata_o  = '0;
      pop           = 1'b0;
      if (!empty) begin
         if (head == ERR) begin
            data_rvalid_o = 1'b1;
            data_err_o    = 1'b1;
            pop           = 1'b1;
         end else begin
            for (int k = 0; k < NSLV; k++) begin
               if (head == IW'(k)) begin
                  data_rvalid_o = s_rvalid_i[k];
                  data_rdata_o  = s_rdata_i[k*DW +: DW];
                  pop           = s_rvalid_i[k];
               end
            end
         end
      end
   end

   resp_id_fifo #(
      .DEPTH (OUTST),
      .W     (IW)
   ) u_resp_id_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (data_gnt_o),
      .pop_i   (pop),
      .din_i   (target),
      .dout_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .last_o  (last)
   );

endmodule

`default_nettype wire

// File: tb/tb_dbus_decoder.sv
// ---------------------------------------------------------------------------
// tb_dbus_decoder: directed vector table plus multi-cycle sequences. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dbus_decoder;

   localparam int NSLV = 4;
   localparam int DW   = 32;
   localparam int AW   = 32;
   localparam int SW   = 4;

   logic               clk = 1'b0;
   logic               rst_ni = 1'b0;
   logic               data_req_i = 1'b0;
   logic               data_gnt_o;
   logic               data_we_i = 1'b0;
   logic [SW-1:0]      data_be_i = '0;
   logic [AW-1:0]      data_addr_i = '0;
   logic [DW-1:0]      data_wdata_i = '0;
   logic               data_rvalid_o;
   logic [DW-1:0]      data_rdata_o;
   logic               data_err_o;
   logic [NSLV-1:0]    s_req_o;
   logic               s_we_o;
   logic [SW-1:0]      s_be_o;
   logic [AW-1:0]      s_addr_o;
   logic [DW-1:0]      s_wdata_o;
   logic [NSLV-1:0]    s_rvalid_i = '0;
   logic [NSLV*DW-1:0] s_rdata_i = '0;

   dbus_decoder u_dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .data_req_i    (data_req_i),
      .data_gnt_o    (data_gnt_o),
      .data_we_i     (data_we_i),
      .data_be_i     (data_be_i),
      .data_addr_i   (data_addr_i),
      .data_wdata_i  (data_wdata_i),
      .data_rvalid_o (data_rvalid_o),
      .data_rdata_o  (data_rdata_o),
      .data_err_o    (data_err_o),
      .s_req_o       (s_req_o),
      .s_we_o        (s_we_o),
      .s_be_o        (s_be_o),
      .s_addr_o      (s_addr_o),
      .s_wdata_o     (s_wdata_o),
      .s_rvalid_i    (s_rvalid_i),
      .s_rdata_i     (s_rdata_i)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Lane k of the slave read-data bus carries base + k
   task automatic set_lanes(input logic [31:0] base);
      for (int k = 0; k < NSLV; k++) s_rdata_i[k*DW +: DW] = base + 32'(k);
   endtask

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [3:0]  sreq;
      logic [31:0] saddr;
      logic [31:0] rdat;
   } vec_t;

   vec_t vt[10];

   initial begin
      vt[0] = '{32'h0000_1008, 1'b0, 4'hF, 32'h0,  4'b0001, 32'h8,   32'hDEAD_BEEF};
      vt[1] = '{32'h0000_2008, 1'b1, 4'h1, 32'h55, 4'b0100, 32'h4,   32'h1000_0000};
      vt[2] = '{32'h0000_0000, 1'b0, 4'hF, 32'h0,  4'b0000, 32'h0,   32'h2000_0000};
      vt[3] = '{32'h0000_2014, 1'b0, 4'hF, 32'h0,  4'b1000, 32'h0,   32'h3000_0000};
      vt[4] = '{32'h0000_2000, 1'b1, 4'h3, 32'hA5, 4'b0010, 32'h0,   32'h4000_0000};
      vt[5] = '{32'h0000_1FFF, 1'b0, 4'h8, 32'h0,  4'b0001, 32'hFFF, 32'h5000_0000};
      vt[6] = '{32'h0000_2003, 1'b0, 4'h8, 32'h0,  4'b0010, 32'h3,   32'h6000_0000};
      vt[7] = '{32'h0000_2034, 1'b0, 4'hF, 32'h0,  4'b0000, 32'h0,   32'h7000_0000};
      vt[8] = '{32'h0000_0FFF, 1'b0, 4'hF, 32'h0,  4'b0000, 32'h0,   32'h8000_0000};
      vt[9] = '{32'hFFFF_FFFF, 1'b0, 4'hF, 32'h0,  4'b0000, 32'h0,   32'h9000_0000};

      // Reset state
      repeat (2) tick();
      rst_ni = 1'b1;
      #1;
      chk("rst_gnt",    32'(data_gnt_o),    32'h0);
      chk("rst_rvalid", 32'(data_rvalid_o), 32'h0);
      chk("rst_err",    32'(data_err_o),    32'h0);
      chk("rst_rdata",  data_rdata_o,       32'h0);
      chk("rst_sreq",   32'(s_req_o),       32'h0);

      // Single transactions from the vector table
      for (int i = 0; i < 10; i++) begin
         int sel;
         sel = -1;
         for (int k = 0; k < NSLV; k++) if (vt[i].sreq[k]) sel = k;
         tick();
         data_req_i   = 1'b1;
         data_addr_i  = vt[i].addr;
         data_we_i    = vt[i].we;
         data_be_i    = vt[i].be;
         data_wdata_i = vt[i].wdata;
         set_lanes(vt[i].rdat);
         #1;
         chk($sformatf("v%0d_gnt", i),  32'(data_gnt_o), 32'h1);
         chk($sformatf("v%0d_sreq", i), 32'(s_req_o),    32'(vt[i].sreq));
         if (sel >= 0) begin
            chk($sformatf("v%0d_saddr", i), s_addr_o,     vt[i].saddr);
            chk($sformatf("v%0d_swd", i),   s_wdata_o,    vt[i].wdata);
            chk($sformatf("v%0d_swe", i),   32'(s_we_o),  32'(vt[i].we));
            chk($sformatf("v%0d_sbe", i),   32'(s_be_o),  32'(vt[i].be));
         end
         tick();
         data_req_i = 1'b0;
         if (sel >= 0) s_rvalid_i = vt[i].sreq;
         #1;
         chk($sformatf("v%0d_rvalid", i), 32'(data_rvalid_o), 32'h1);
         chk($sformatf("v%0d_err", i),    32'(data_err_o),    (sel >= 0) ? 32'h0 : 32'h1);
         chk($sformatf("v%0d_rdata", i),  data_rdata_o,
             (sel >= 0) ? vt[i].rdat + 32'(sel) : 32'h0);
         tick();
         s_rvalid_i = '0;
         #1;
         chk($sformatf("v%0d_idle", i), 32'(data_rvalid_o), 32'h0);
      end

      // RAM read with latency 3, Timer request must wait for it
      data_we_i = 1'b0;
      data_be_i = 4'hF;
      tick();
      data_req_i  = 1'b1;
      data_addr_i = 32'h0000_1000;
      set_lanes(32'hA000_0000);
      #1;
      chk("sa_ram_gnt", 32'(data_gnt_o), 32'h1);
      tick();
      data_addr_i = 32'h0000_2014;
      #1;
      chk("sa_tmr_stall1", 32'(data_gnt_o), 32'h0);
      chk("sa_tmr_sreq1",  32'(s_req_o),    32'h0);
      tick();
      #1;
      chk("sa_tmr_stall2", 32'(data_gnt_o), 32'h0);
      tick();
      s_rvalid_i = 4'b0001;
      #1;
      chk("sa_tmr_stall3", 32'(data_gnt_o),    32'h0);
      chk("sa_ram_rvalid", 32'(data_rvalid_o), 32'h1);
      chk("sa_ram_rdata",  data_rdata_o,       32'hA000_0000);
      tick();
      s_rvalid_i = '0;
      #1;
      chk("sa_tmr_gnt",   32'(data_gnt_o), 32'h1);
      chk("sa_tmr_sreq",  32'(s_req_o),    32'h8);
      chk("sa_tmr_saddr", s_addr_o,        32'h0);
      tick();
      data_req_i = 1'b0;
      s_rvalid_i = 4'b1000;
      #1;
      chk("sa_tmr_rdata", data_rdata_o, 32'hA000_0003);
      tick();
      s_rvalid_i = '0;

      // Three RAM reads, FIFO fills after two; responses 1,2,3 in order
      data_req_i  = 1'b1;
      data_addr_i = 32'h0000_1000;
      #1;
      chk("sb_gnt1", 32'(data_gnt_o), 32'h1);
      tick();
      data_addr_i = 32'h0000_1004;
      #1;
      chk("sb_gnt2", 32'(data_gnt_o), 32'h1);
      tick();
      data_addr_i = 32'h0000_1008;
      s_rvalid_i  = 4'b0001;
      set_lanes(32'h1);
      #1;
      chk("sb_gnt3_full", 32'(data_gnt_o), 32'h0);
      chk("sb_rdata1",    data_rdata_o,    32'h1);
      tick();
      set_lanes(32'h2);
      #1;
      chk("sb_gnt3",   32'(data_gnt_o),    32'h1);
      chk("sb_rv2",    32'(data_rvalid_o), 32'h1);
      chk("sb_rdata2", data_rdata_o,       32'h2);
      tick();
      data_req_i = 1'b0;
      set_lanes(32'h3);
      #1;
      chk("sb_rv3",    32'(data_rvalid_o), 32'h1);
      chk("sb_rdata3", data_rdata_o,       32'h3);
      tick();
      s_rvalid_i  = '0;
      data_req_i  = 1'b1;
      data_addr_i = 32'h0000_2014;
      #1;
      chk("sb_drained_gnt", 32'(data_gnt_o), 32'h1);
      tick();
      data_req_i = 1'b0;
      s_rvalid_i = 4'b1000;
      tick();
      s_rvalid_i = '0;

      // Reset with two RAM reads outstanding
      data_req_i  = 1'b1;
      data_addr_i = 32'h0000_1000;
      #1;
      chk("sc_gnt1", 32'(data_gnt_o), 32'h1);
      tick();
      data_addr_i = 32'h0000_1004;
      #1;
      chk("sc_gnt2", 32'(data_gnt_o), 32'h1);
      tick();
      data_req_i = 1'b0;
      rst_ni     = 1'b0;
      tick();
      rst_ni      = 1'b1;
      s_rvalid_i  = 4'b0001;
      data_req_i  = 1'b1;
      data_addr_i = 32'h0000_2014;
      set_lanes(32'hC000_0000);
      #1;
      chk("sc_late_rvalid", 32'(data_rvalid_o), 32'h0);
      chk("sc_late_err",    32'(data_err_o),    32'h0);
      chk("sc_tmr_gnt",     32'(data_gnt_o),    32'h1);
      chk("sc_tmr_sreq",    32'(s_req_o),       32'h8);
      tick();
      data_req_i = 1'b0;
      s_rvalid_i = 4'b1000;
      #1;
      chk("sc_tmr_rvalid", 32'(data_rvalid_o), 32'h1);
      chk("sc_tmr_rdata",  data_rdata_o,       32'hC000_0003);
      tick();
      s_rvalid_i = '0;
      #1;
      chk("sc_idle", 32'(data_rvalid_o), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
